seq_check_prog: RTL and testbench

//  Runtime-programmable serial bit-pattern detector; parametrised successor of the fixed 6-bit FSM checker.

---
 rtl/seq_check_pkg.sv | 23 ++
 rtl/seq_check_if.sv | 34 +++
 rtl/seq_hist_shift.sv | 61 ++++++
 rtl/seq_check_prog.sv | 113 +++++++++++
 tb/tb_seq_check_prog.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/seq_check_pkg.sv
// ---------------------------------------------------------------------------
// seq_check_pkg
// Shared constants and helpers for the programmable serial pattern detector.
//   DEF_PATTERN / DEF_LEN / DEF_OVERLAP : configuration loaded on reset
//   len_mask(len)                       : low-'len' bits set, used to ignore
//                                         pattern/history bits above length
// ---------------------------------------------------------------------------
package seq_check_pkg;

    localparam logic [7:0] DEF_PATTERN = 8'b0010_1001;
    localparam int         DEF_LEN     = 6;
    localparam logic       DEF_OVERLAP = 1'b1;

    // Callers truncate the result to their own pattern width.
    function automatic logic [63:0] len_mask(input int unsigned len);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_check_if.sv
// ---------------------------------------------------------------------------
// seq_check_if
// Configuration + serial data bus for seq_check_prog.
//   cfg_we/cfg_pattern/cfg_len/cfg_overlap : configuration load
//   data_valid/data_in                     : serial stream
//   flag/match_cnt                         : detector results
// Modports: master (stream/config source), slave (detector).
// ---------------------------------------------------------------------------
interface seq_check_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               data_valid;
    logic               data_in;
    logic               flag;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, data_valid, data_in,
        input  flag, match_cnt
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, data_valid, data_in,
        output flag, match_cnt
    );

endinterface

// File: rtl/seq_hist_shift.sv
// ---------------------------------------------------------------------------
// seq_hist_shift
// History shift register plus saturating fill counter for the detector.
//   clk, rst_n     : clock, async active-low reset
//   clr_i          : clear history and fill (wins over shift_i)
//   shift_i        : shift din_i in, fill += 1 (saturates at MAX_LEN)
//   fill_clr_i     : with shift_i, restart fill at 0 (non-overlap restart)
//   din_i          : serial bit
//   hist_shift_o   : history as it would be after shifting din_i in
//   fill_o         : number of valid bits held (0..MAX_LEN)
// ---------------------------------------------------------------------------
module seq_hist_shift #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic               fill_clr_i,
    input  logic               din_i,
    output logic [MAX_LEN-1:0] hist_shift_o,
    output logic [LEN_W-1:0]   fill_o
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;

    // Exposed combinationally so the compare sees the bit being sampled now.
    assign hist_shift_o = {hist_q[MAX_LEN-2:0], din_i};
    assign fill_o       = fill_q;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            // Stale history bits after a fill restart are harmless: the
            // fill gate keeps them out of the next compare.
            hist_d = hist_shift_o;
            if (fill_clr_i) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_check_prog.sv
// ---------------------------------------------------------------------------
// seq_check_prog
// Runtime-programmable serial bit-pattern detector (sync-word search).
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_check_if.slave -- config load, serial data, flag and
//                match counter
// flag pulses for one cycle after the edge that samples the last pattern bit.
// Optional feature: define SEQ_MATCH_CNT_EN to build the saturating match
// counter; otherwise match_cnt is tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module seq_check_prog
    import seq_check_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_check_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               flag_q;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W:0]     fill_inc;
    logic [MAX_LEN-1:0] mask;
    logic               shift;
    logic               match;

    // Configuration wins over data in the same cycle.
    assign shift = bus.data_valid & ~bus.cfg_we;

    seq_hist_shift #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (bus.cfg_we),
        .shift_i      (shift),
        .fill_clr_i   (match & ~ovl_q),
        .din_i        (bus.data_in),
        .hist_shift_o (hist_shift),
        .fill_o       (fill)
    );

    always_comb begin
        fill_inc = {1'b0, fill} + 1'b1;
        mask     = MAX_LEN'(len_mask(int'(len_q)));
        // len 0 must be excluded explicitly: an empty mask compares equal.
        match    = shift && (len_q != '0) && (fill_inc >= {1'b0, len_q})
                   && (((hist_shift ^ pat_q) & mask) == '0);
    end

    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        ovl_d = ovl_q;
        if (bus.cfg_we) begin
            pat_d = bus.cfg_pattern;
            ovl_d = bus.cfg_overlap;
            len_d = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= MAX_LEN'(DEF_PATTERN);
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            flag_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            flag_q <= match;
        end
    end

    assign bus.flag = flag_q;

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cfg_we) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_check_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_check_prog
// Directed stimulus for seq_check_prog with a queue-based reference model
// and per-bit literal expectations. Build with or without SEQ_MATCH_CNT_EN.
// ---------------------------------------------------------------------------
module tb_seq_check_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
`ifdef SEQ_MATCH_CNT_EN
    localparam int CNT_LIM = 15;
`else
    localparam int CNT_LIM = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_check_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_check_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // Keeps the bits received since the last clear/restart and asks whether
    // the newest 'len' of them spell the pattern.
    bit         bits_q[$];
    logic [7:0] m_pat = 8'b0010_1001;
    int         m_len = 6;
    bit         m_ovl = 1'b1;
    bit         exp_flag = 1'b0;
    int         exp_cnt = 0;
    bit         hit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q.delete();
            m_pat = 8'b0010_1001; m_len = 6; m_ovl = 1'b1;
            exp_flag = 1'b0; exp_cnt = 0;
        end else if (bus.cfg_we) begin
            bits_q.delete();
            m_pat = bus.cfg_pattern;
            m_len = (int'(bus.cfg_len) > MAX_LEN) ? MAX_LEN : int'(bus.cfg_len);
            m_ovl = bus.cfg_overlap;
            exp_flag = 1'b0; exp_cnt = 0;
        end else if (bus.data_valid) begin
            bits_q.push_back(bus.data_in);
            if (bits_q.size() > 64) void'(bits_q.pop_front());
            hit = (m_len > 0) && (bits_q.size() >= m_len);
            if (hit) begin
                for (int i = 0; i < m_len; i++) begin
                    if (bits_q[bits_q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
                end
            end
            exp_flag = hit;
            if (hit) begin
                if (exp_cnt < CNT_LIM) exp_cnt++;
                if (!m_ovl) bits_q.delete();
            end
        end else begin
            exp_flag = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if (bus.flag !== exp_flag) begin
                miscompares++;
                $display("FAIL model_flag t=%0t got=%0b want=%0b", $time, bus.flag, exp_flag);
            end
            vectors++;
            if (int'(bus.match_cnt) != exp_cnt || $isunknown(bus.match_cnt)) begin
                miscompares++;
                $display("FAIL model_cnt t=%0t got=%0d want=%0d", $time, bus.match_cnt, exp_cnt);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp_v);
        end
    endtask

    task automatic step(input bit v, input bit b);
        @(negedge clk);
        bus.data_valid = v;
        bus.data_in    = b;
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o, input bit v);
        @(negedge clk);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = o;
        bus.data_valid  = v;
        bus.data_in     = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_we     = 1'b0;
        bus.data_valid = 1'b0;
    endtask

    // Bits and expected flags listed first-bit-first (MSB of the vector).
    task automatic run_seq(input string nm, input logic [31:0] bv, input logic [31:0] ev, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bv[i]);
            chk(nm, int'(bus.flag), int'(ev[i]));
        end
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
        bus.cfg_overlap = 1'b0; bus.data_valid = 1'b0; bus.data_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flag", int'(bus.flag), 0);
        chk("reset_cnt", int'(bus.match_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default pattern 101001 straight out of reset.
        run_seq("t1_default", 32'b101001, 32'b000001, 6);
        chk("t1_cnt", int'(bus.match_cnt), (CNT_LIM > 0) ? 1 : 0);
        step(1'b0, 1'b0);
        chk("t1_pulse_end", int'(bus.flag), 0);

        // 101001's only self-overlap is a single '1', so with overlap the
        // next match can end 5 bits after the first.
        load(8'b0010_1001, 4'd6, 1'b1, 1'b0);
        run_seq("t2_overlap", 32'b10100101001, 32'b00000100001, 11);
        load(8'b0010_1001, 4'd6, 1'b0, 1'b0);
        run_seq("t2_no_overlap", 32'b10100101001, 32'b00000100000, 11);

        // Idle cycles inside a match.
        load(8'b0010_1001, 4'd6, 1'b1, 1'b0);
        run_seq("t3_head", 32'b101, 32'b000, 3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk("t3_gap", int'(bus.flag), 0);
        end
        run_seq("t3_tail", 32'b001, 32'b001, 3);

        // Reconfigure mid-stream with a valid bit in the load cycle (ignored).
        run_seq("t4_pre", 32'b101, 32'b000, 3);
        load(8'hFF, 4'd8, 1'b1, 1'b1);
        run_seq("t4_ones", 32'b111111111, 32'b000000011, 9);

        // Disabled detector on random data.
        load(8'hFF, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            chk("t5_len0", int'(bus.flag), 0);
        end
        // Length beyond MAX_LEN acts as MAX_LEN.
        load(8'hFF, 4'd12, 1'b1, 1'b0);
        run_seq("t5_clamp", 32'b11111111, 32'b00000001, 8);

        // Reset in the middle of a would-be match.
        load(8'b0010_1001, 4'd6, 1'b1, 1'b0);
        run_seq("t5_pre_rst", 32'b1010, 32'b0000, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("t5_rst_flag", int'(bus.flag), 0);
        chk("t5_rst_cnt", int'(bus.match_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("t5_post_rst", 32'b01, 32'b00, 2);
        chk("t5_post_cnt", int'(bus.match_cnt), 0);

        // Pattern bits above len are ignored: 0xAB with len 2 means "11".
        load(8'hAB, 4'd2, 1'b1, 1'b0);
        for (int i = 0; i < 21; i++) step(1'b1, 1'b1);
        chk("t6_last_flag", int'(bus.flag), 1);
        chk("t6_cnt_sat", int'(bus.match_cnt), CNT_LIM);

        step(1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
